// File: rtl/seq_pkg.sv
// Shared constants and helpers for the sequential pipeline blocks.
package seq_pkg;

    localparam int MAX_DEPTH = 16;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2_p1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n + 1) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid/data register pair plus its local ready term.
module pipe_stage
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    // An empty stage always accepts, which is what collapses bubbles.
    assign ready = ~valid | dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
// Handshakes: a word moves on an edge where valid & ready are both 1; ready may
// depend combinationally on downstream ready, valid never depends on ready.
module pipe_chain
    import seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("pipe_chain: DEPTH out of range");
    end

    logic in_hs;
    logic out_hs;

    // Per-stage signals live in each generate scope so the ready chain is a
    // set of distinct nets rather than bits of one vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             rdy;
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_r;

        if (i == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_mid
            assign up_v = g_stage[i-1].vld;
            assign up_d = g_stage[i-1].dat;
        end

        if (i == DEPTH - 1) begin : g_last
            assign dn_r = out_ready;
        end else begin : g_inner
            assign dn_r = g_stage[i+1].rdy;
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .up_valid(up_v),
            .up_data (up_d),
            .dn_ready(dn_r),
            .valid   (vld),
            .data    (dat),
            .ready   (rdy)
        );
    end

    assign in_ready  = g_stage[0].rdy & ~flush & ~rst;
    // The last stage is masked during flush so nothing can pop as it clears.
    assign out_valid = g_stage[DEPTH-1].vld & ~flush;
    assign out_data  = g_stage[DEPTH-1].dat;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_hs) - CW'(out_hs);
        end
    end

endmodule
